// File: rtl/itcm_boot_loader_pkg.sv
// Shared types and constants for the ITCM serial boot loader.
package itcm_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CNT_LO,
        CNT_HI,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

    localparam logic [7:0] BOOT_MAGIC     = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/itcm_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words and keeps the mod-256 byte sum.
module itcm_word_assembler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic [7:0]  sum_o,
    output logic        last_o
);
    import itcm_boot_loader_pkg::*;

    localparam int LW = $clog2(BYTES_PER_WORD);

    logic [LW-1:0] lane_q;
    logic [31:0]   word_q;
    logic [7:0]    sum_q;

    // Shifting in from the top leaves byte i in lane i once the word is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            word_q <= '0;
            sum_q  <= '0;
        end else if (clear_i) begin
            lane_q <= '0;
            word_q <= '0;
            sum_q  <= '0;
        end else if (load_i) begin
            lane_q <= lane_q + 1'b1;
            word_q <= {byte_i, word_q[31:8]};
            sum_q  <= sum_q + byte_i;
        end
    end

    assign word_o = word_q;
    assign sum_o  = sum_q;
    assign last_o = (lane_q == LW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/itcm_boot_loader.sv
// Serial boot-image loader: owns the ITCM port while a framed image is written,
// holding the CPU in reset until the checksum has been verified.
module itcm_boot_loader #(
    parameter int AW      = 14,
    parameter int TIMEOUT = 27000000,
    parameter int TMO_W   = 25
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic [7:0]    RX_DATA,
    input  logic          RX_VALID,
    output logic          RX_READY,
    input  logic [AW-1:0] BUS_ADDR,
    input  logic [31:0]   BUS_WDATA,
    input  logic [3:0]    BUS_WEN,
    input  logic          BUS_CS,
    output logic [31:0]   BUS_RDATA,
    output logic [AW-1:0] TCM_ADDR,
    output logic [31:0]   TCM_WDATA,
    output logic [3:0]    TCM_WEN,
    output logic          TCM_CS,
    input  logic [31:0]   TCM_RDATA,
    output logic          CPU_HOLD,
    output logic          LOAD_BUSY,
    output logic          LOAD_DONE,
    output logic          LOAD_ERR
);
    import itcm_boot_loader_pkg::*;

    loader_state_e    state_q;
    logic             cpu_hold_q, busy_q, done_q, err_q;
    logic [AW:0]      idx_q, cnt_q;
    logic [7:0]       cnt_lo_q;
    logic [TMO_W-1:0] tmo_q;

    logic        accept, is_magic, bus_owns, timed_state, tmo_hit;
    logic        asm_clear, asm_load, asm_last;
    logic [31:0] asm_word;
    logic [7:0]  asm_sum;
    logic [16:0] n_full, n_limit;

    assign bus_owns    = (state_q == IDLE) || (state_q == ERR);
    assign RX_READY    = (state_q != WRITE);
    assign accept      = RX_VALID & RX_READY;
    assign is_magic    = (RX_DATA == BOOT_MAGIC);
    assign timed_state = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                         (state_q == DATA)   || (state_q == CSUM);
    assign tmo_hit     = timed_state && !accept && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign n_full      = {1'b0, RX_DATA, cnt_lo_q};
    assign n_limit     = 17'd1 << AW;
    assign asm_clear   = accept && is_magic &&
                         (bus_owns || (state_q == DONE));
    assign asm_load    = accept && (state_q == DATA);

    itcm_word_assembler u_asm (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .clear_i (asm_clear),
        .load_i  (asm_load),
        .byte_i  (RX_DATA),
        .word_o  (asm_word),
        .sum_o   (asm_sum),
        .last_o  (asm_last)
    );

    // Timer reads 1 in the cycle after an accept, so ERR lands exactly TIMEOUT cycles later.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= IDLE;
            cpu_hold_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            cnt_lo_q   <= '0;
            tmo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept)
                tmo_q <= TMO_W'(1);
            else if (tmo_q != '1)
                tmo_q <= tmo_q + 1'b1;

            if (tmo_hit) begin
                state_q <= ERR;
                err_q   <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE, ERR, DONE: begin
                        if (accept && is_magic) begin
                            state_q    <= CNT_LO;
                            cpu_hold_q <= 1'b1;
                            busy_q     <= 1'b1;
                            err_q      <= 1'b0;
                            idx_q      <= '0;
                        end else if (state_q == DONE) begin
                            state_q <= IDLE;
                        end
                    end
                    CNT_LO: begin
                        if (accept) begin
                            cnt_lo_q <= RX_DATA;
                            state_q  <= CNT_HI;
                        end
                    end
                    CNT_HI: begin
                        if (accept) begin
                            if (n_full > n_limit) begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                                busy_q  <= 1'b0;
                            end else if (n_full == '0) begin
                                state_q <= CSUM;
                            end else begin
                                cnt_q   <= n_full[AW:0];
                                state_q <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (accept && asm_last)
                            state_q <= WRITE;
                    end
                    WRITE: begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= ((idx_q + 1'b1) == cnt_q) ? CSUM : DATA;
                    end
                    CSUM: begin
                        if (accept) begin
                            busy_q <= 1'b0;
                            if (RX_DATA == asm_sum) begin
                                state_q    <= DONE;
                                done_q     <= 1'b1;
                                cpu_hold_q <= 1'b0;
                            end else begin
                                state_q <= ERR;
                                err_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Bus requests are dropped entirely while the loader owns the macro.
    always_comb begin
        if (bus_owns) begin
            TCM_ADDR  = BUS_ADDR;
            TCM_WDATA = BUS_WDATA;
            TCM_WEN   = BUS_WEN & {4{BUS_CS}};
            TCM_CS    = BUS_CS;
        end else begin
            TCM_ADDR  = idx_q[AW-1:0];
            TCM_WDATA = asm_word;
            TCM_WEN   = {4{state_q == WRITE}};
            TCM_CS    = (state_q == WRITE);
        end
    end

    assign BUS_RDATA = TCM_RDATA;
    assign CPU_HOLD  = cpu_hold_q;
    assign LOAD_BUSY = busy_q;
    assign LOAD_DONE = done_q;
    assign LOAD_ERR  = err_q;

endmodule

// File: tb/tb_itcm_boot_loader.sv
// Scoreboard bench for itcm_boot_loader: frames push expected writes/events, a monitor checks them.
module tb_itcm_boot_loader;

    localparam int AW      = 4;
    localparam int TIMEOUT = 20;
    localparam int TMO_W   = 5;

    logic          HCLK = 1'b0;
    logic          HRESETn = 1'b0;
    logic [7:0]    RX_DATA = '0;
    logic          RX_VALID = 1'b0;
    logic          RX_READY;
    logic [AW-1:0] BUS_ADDR = '0;
    logic [31:0]   BUS_WDATA = '0;
    logic [3:0]    BUS_WEN = '0;
    logic          BUS_CS = 1'b0;
    logic [31:0]   BUS_RDATA;
    logic [AW-1:0] TCM_ADDR;
    logic [31:0]   TCM_WDATA;
    logic [3:0]    TCM_WEN;
    logic          TCM_CS;
    logic [31:0]   TCM_RDATA = 32'hDEADBEEF;
    logic          CPU_HOLD, LOAD_BUSY, LOAD_DONE, LOAD_ERR;

    itcm_boot_loader #(.AW(AW), .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA), .BUS_WEN(BUS_WEN), .BUS_CS(BUS_CS),
        .BUS_RDATA(BUS_RDATA),
        .TCM_ADDR(TCM_ADDR), .TCM_WDATA(TCM_WDATA), .TCM_WEN(TCM_WEN), .TCM_CS(TCM_CS),
        .TCM_RDATA(TCM_RDATA),
        .CPU_HOLD(CPU_HOLD), .LOAD_BUSY(LOAD_BUSY), .LOAD_DONE(LOAD_DONE), .LOAD_ERR(LOAD_ERR)
    );

    always #5 HCLK = ~HCLK;

    int errorCount = 0;
    int checkCount = 0;
    int readyLowCount = 0;
    logic prevErr = 1'b0;
    logic [AW+31:0] expWrites[$];
    int expEvents[$];
    logic [7:0] frameData[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        int guard = 0;
        @(negedge HCLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        while (!RX_READY && guard < 50) begin
            @(negedge HCLK);
            guard++;
        end
        if (!RX_READY) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL rxReadyStuck: got 0, expected 1 within 50 cycles");
            RX_VALID = 1'b0;
        end else begin
            @(posedge HCLK);
            #1 RX_VALID = 1'b0;
        end
    endtask

    // Sends a whole frame from frameData and queues what the DUT must produce.
    task automatic applyStimulus(input logic [15:0] n, input logic [7:0] csum, input bit expectGood);
        for (int k = 0; k < int'(n); k++)
            expWrites.push_back({AW'(k), frameData[4*k+3], frameData[4*k+2],
                                 frameData[4*k+1], frameData[4*k]});
        expEvents.push_back(expectGood ? 1 : 2);
        readyLowCount = 0;
        sendByte(8'hA5);
        @(negedge HCLK);
        checkOutput("holdAfterMagic", 32'(CPU_HOLD), 32'd1);
        checkOutput("busyAfterMagic", 32'(LOAD_BUSY), 32'd1);
        checkOutput("errClearedByMagic", 32'(LOAD_ERR), 32'd0);
        sendByte(n[7:0]);
        sendByte(n[15:8]);
        for (int i = 0; i < frameData.size(); i++)
            sendByte(frameData[i]);
        sendByte(csum);
        @(negedge HCLK);
        if (expectGood) begin
            checkOutput("donePulse", 32'(LOAD_DONE), 32'd1);
            checkOutput("holdReleased", 32'(CPU_HOLD), 32'd0);
        end else begin
            checkOutput("errSet", 32'(LOAD_ERR), 32'd1);
            checkOutput("holdKeptOnErr", 32'(CPU_HOLD), 32'd1);
        end
        checkOutput("busyAfterCsum", 32'(LOAD_BUSY), 32'd0);
        checkOutput("readyLowCycles", 32'(readyLowCount), 32'(n));
    endtask

    // Monitor: every loader-side write and every status event is matched against the queues.
    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (!RX_READY) begin
                readyLowCount++;
                checkOutput("readyLowOnlyInWrite", {26'b0, LOAD_BUSY, TCM_CS, TCM_WEN}, 32'h3F);
            end
            if (LOAD_BUSY && TCM_CS) begin
                if (expWrites.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h, expected none", TCM_ADDR, TCM_WDATA);
                end else begin
                    logic [AW+31:0] e;
                    e = expWrites.pop_front();
                    checkOutput("writeAddr", 32'(TCM_ADDR), 32'(e[AW+31:32]));
                    checkOutput("writeData", TCM_WDATA, e[31:0]);
                    checkOutput("writeWen", 32'(TCM_WEN), 32'hF);
                end
            end
            if (LOAD_DONE || (LOAD_ERR && !prevErr)) begin
                if (expEvents.size() == 0) begin
                    checkCount++;
                    errorCount++;
                    $display("[TB] FAIL unexpectedEvent: got done=%0d err=%0d, expected none", LOAD_DONE, LOAD_ERR);
                end else begin
                    checkOutput("eventKind", LOAD_DONE ? 32'd1 : 32'd2, 32'(expEvents.pop_front()));
                end
            end
        end
        prevErr = LOAD_ERR;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] s;
        #1;
        checkOutput("rstReady", 32'(RX_READY), 32'd1);
        checkOutput("rstHold", 32'(CPU_HOLD), 32'd0);
        checkOutput("rstBusy", 32'(LOAD_BUSY), 32'd0);
        checkOutput("rstDone", 32'(LOAD_DONE), 32'd0);
        checkOutput("rstErr", 32'(LOAD_ERR), 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        @(negedge HCLK);
        BUS_CS = 1'b1; BUS_WEN = 4'h3; BUS_ADDR = 4'd5; BUS_WDATA = 32'h12345678; TCM_RDATA = 32'hCAFEF00D;
        #1;
        checkOutput("passWen", 32'(TCM_WEN), 32'h3);
        checkOutput("passAddr", 32'(TCM_ADDR), 32'd5);
        checkOutput("passCs", 32'(TCM_CS), 32'd1);
        checkOutput("passWdata", TCM_WDATA, 32'h12345678);
        checkOutput("passRdata", BUS_RDATA, 32'hCAFEF00D);
        BUS_CS = 1'b0; BUS_WEN = 4'hF;
        #1;
        checkOutput("passWenQualified", 32'(TCM_WEN), 32'h0);
        BUS_WEN = 4'h0;

        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'h5A);
        @(negedge HCLK);
        checkOutput("garbageHold", 32'(CPU_HOLD), 32'd0);
        checkOutput("garbageBusy", 32'(LOAD_BUSY), 32'd0);

        frameData = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        applyStimulus(16'd2, 8'h64, 1'b1);
        applyStimulus(16'd2, 8'h65, 1'b0);
        applyStimulus(16'd2, 8'h64, 1'b1);

        frameData = '{};
        applyStimulus(16'd0, 8'h00, 1'b1);

        expEvents.push_back(2);
        sendByte(8'hA5);
        sendByte(8'h11);
        sendByte(8'h00);
        @(negedge HCLK);
        checkOutput("oversizeErr", 32'(LOAD_ERR), 32'd1);
        checkOutput("oversizeHold", 32'(CPU_HOLD), 32'd1);

        frameData = '{};
        s = 8'h00;
        for (int i = 0; i < 64; i++) begin
            frameData.push_back(8'(i * 7 + 3));
            s = s + 8'(i * 7 + 3);
        end
        applyStimulus(16'd16, s, 1'b1);

        expEvents.push_back(2);
        sendByte(8'hA5);
        sendByte(8'h01);
        sendByte(8'h00);
        sendByte(8'hC1);
        sendByte(8'hC2);
        sendByte(8'hC3);
        for (int k = 1; k < TIMEOUT; k++) @(negedge HCLK);
        checkOutput("tmoNotYet", 32'(LOAD_ERR), 32'd0);
        @(negedge HCLK);
        checkOutput("tmoErr", 32'(LOAD_ERR), 32'd1);
        checkOutput("tmoHold", 32'(CPU_HOLD), 32'd1);
        checkOutput("tmoBusy", 32'(LOAD_BUSY), 32'd0);

        sendByte(8'hA5);
        sendByte(8'h02);
        sendByte(8'h00);
        sendByte(8'h11);
        sendByte(8'h22);
        @(negedge HCLK);
        BUS_CS = 1'b1; BUS_WEN = 4'h5; BUS_ADDR = 4'd9;
        HRESETn = 1'b0;
        #1;
        checkOutput("midRstHold", 32'(CPU_HOLD), 32'd0);
        checkOutput("midRstBusy", 32'(LOAD_BUSY), 32'd0);
        checkOutput("midRstErr", 32'(LOAD_ERR), 32'd0);
        checkOutput("midRstReady", 32'(RX_READY), 32'd1);
        checkOutput("midRstTcmWen", 32'(TCM_WEN), 32'h5);
        checkOutput("midRstTcmAddr", 32'(TCM_ADDR), 32'd9);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        BUS_CS = 1'b0; BUS_WEN = 4'h0;
        repeat (3) @(negedge HCLK);

        checkOutput("writesDrained", 32'(expWrites.size()), 32'd0);
        checkOutput("eventsDrained", 32'(expEvents.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
